branch_ctrl: RTL

Branch resolution controller for the EX stage. Drives the comparator signedness select and takes the equal/less-than results back from the comparator. Decodes the branch condition and compares the outcome against the front-end prediction. On a mispredict it issues a one-cycle PC redirect and holds a multi-cycle pipeline flush/stall sequence. It also keeps a saturating mispredict counter.

---
 rtl/branch_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch resolution, PC redirect and flush control.
// Optional 2-bit BHT is built when BRANCH_CTRL_BHT_EN is defined.
module branch_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16,
   parameter int BHT_IDX_W    = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Br_Valid,
   output logic             Br_Ready,
   input  logic [2:0]       Br_Funct3,
   input  logic             Br_Is_Jump,
   input  logic [31:0]      Br_Pc,
   input  logic [31:0]      Br_Target,
   input  logic             Br_Pred_Taken,
   output logic             Branch_Un_Ctrl,
   input  logic             Branch_Equal,
   input  logic             Branch_Lt,
   output logic             Redirect_Valid,
   output logic [31:0]      Redirect_Pc,
   output logic             Flush,
   output logic             Stall,
   output logic             Illegal_Br,
`ifdef BRANCH_CTRL_BHT_EN
   input  logic [31:0]      Fetch_Pc,
   output logic             Fetch_Pred_Taken,
`endif
   output logic [CNT_W-1:0] Mispredict_Cnt
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [0:0] state;
   logic [3:0] flush_cnt;
   logic       taken;
   logic       illegal;
   logic       accept;
   logic       mispredict;

   // Comparator signedness follows funct3 bit 1 (BLTU/BGEU)
   assign Branch_Un_Ctrl = Br_Funct3[1];

   assign Br_Ready = (state == ST_IDLE);
   assign Flush    = (state == ST_FLUSH);
   assign Stall    = (state == ST_FLUSH);

   assign accept     = Br_Valid & Br_Ready;
   assign mispredict = accept & ~illegal & (taken != Br_Pred_Taken);

   // Branch condition decode; jumps always resolve taken
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      if (Br_Is_Jump) begin
         taken = 1'b1;
      end else begin
         unique case (Br_Funct3)
            3'b000:  taken = Branch_Equal;
            3'b001:  taken = ~Branch_Equal;
            3'b100:  taken = Branch_Lt;
            3'b101:  taken = ~Branch_Lt;
            3'b110:  taken = Branch_Lt;
            3'b111:  taken = ~Branch_Lt;
            default: illegal = 1'b1;
         endcase
      end
   end

   // Flush FSM: hold FLUSH for FLUSH_CYCLES cycles after a mispredict
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_IDLE;
         flush_cnt <= 4'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (mispredict) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= FLUSH_LAST;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == 4'd0) begin
                  state <= ST_IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               flush_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Redirect strobe and corrected PC; PC holds between redirects
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Redirect_Valid <= 1'b0;
         Redirect_Pc    <= 32'd0;
      end else begin
         Redirect_Valid <= mispredict;
         if (mispredict) begin
            Redirect_Pc <= taken ? Br_Target : Br_Pc + 32'd4;
         end
      end
   end

   // Reserved funct3 pulse, one cycle after the accept
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Illegal_Br <= 1'b0;
      end else begin
         Illegal_Br <= accept & illegal;
      end
   end

   // Saturating mispredict counter
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Mispredict_Cnt <= '0;
      end else if (mispredict && Mispredict_Cnt != CNT_MAX) begin
         Mispredict_Cnt <= Mispredict_Cnt + 1'b1;
      end
   end

`ifdef BRANCH_CTRL_BHT_EN
   localparam int BHT_SIZE = 1 << BHT_IDX_W;

   logic [1:0]           bht [BHT_SIZE];
   logic [BHT_IDX_W-1:0] rd_idx;
   logic [BHT_IDX_W-1:0] wr_idx;
   logic                 bht_upd;
   logic                 unused_fetch;

   assign rd_idx  = Fetch_Pc[BHT_IDX_W+1:2];
   assign wr_idx  = Br_Pc[BHT_IDX_W+1:2];
   assign bht_upd = accept & ~illegal & ~Br_Is_Jump;

   assign Fetch_Pred_Taken = bht[rd_idx][1];

   assign unused_fetch = &{1'b0, Fetch_Pc[31:BHT_IDX_W+2], Fetch_Pc[1:0]};

   // Train the 2-bit counter of each resolved conditional branch
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < BHT_SIZE; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (bht_upd) begin
         if (taken && bht[wr_idx] != 2'b11) begin
            bht[wr_idx] <= bht[wr_idx] + 2'd1;
         end else if (!taken && bht[wr_idx] != 2'b00) begin
            bht[wr_idx] <= bht[wr_idx] - 2'd1;
         end
      end
   end
`endif

endmodule
